// File: rtl/efi_axil_pkg.sv
// Shared constants and FSM state types for the efi_axil_regs AXI4-Lite register block.
package efi_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}                       r_state_t;

   // Expands the four byte strobes into a per-bit write mask.
   function automatic logic [31:0] strb_mask(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

endpackage

// File: rtl/efi_axil_regs_if.sv
// AXI4-Lite slave channel bundle for efi_axil_regs; clock and reset stay outside.
interface efi_axil_regs_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   S_AXI_AWADDR;
   logic [2:0]          S_AXI_AWPROT;
   logic                S_AXI_AWVALID;
   logic                S_AXI_AWREADY;
   logic [DATA_W-1:0]   S_AXI_WDATA;
   logic [DATA_W/8-1:0] S_AXI_WSTRB;
   logic                S_AXI_WVALID;
   logic                S_AXI_WREADY;
   logic [1:0]          S_AXI_BRESP;
   logic                S_AXI_BVALID;
   logic                S_AXI_BREADY;
   logic [ADDR_W-1:0]   S_AXI_ARADDR;
   logic [2:0]          S_AXI_ARPROT;
   logic                S_AXI_ARVALID;
   logic                S_AXI_ARREADY;
   logic [DATA_W-1:0]   S_AXI_RDATA;
   logic [1:0]          S_AXI_RRESP;
   logic                S_AXI_RVALID;
   logic                S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
             S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
             S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/efi_axil_regs.sv
// AXI4-Lite register file with independent write and read FSMs.
// Define EFI_AXIL_WSTRB_EN to honour WSTRB byte lanes; otherwise writes are full-word.
module efi_axil_regs
   import efi_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int C_NUM_REGS         = 4
) (
   input  logic                        S_AXI_ACLK,
   input  logic                        S_AXI_ARESETN,
   efi_axil_regs_if.slave              s_axi,
   output logic [32*C_NUM_REGS-1:0]    reg_out
);

   localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

   logic [C_NUM_REGS-1:0][31:0] regs;
   logic                        live;   // readies stay low until the first edge after reset release

   w_state_t    w_state, w_next;
   logic [IW-1:0] aw_idx_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [1:0]  bresp_q;
   logic        aw_fire, w_fire, commit;
   logic [IW-1:0] c_idx;
   logic [31:0] c_data, c_mask;
   logic [3:0]  c_strb;

   r_state_t    r_state, r_next;
   logic        ar_fire;
   logic [IW-1:0] r_idx;
   logic [31:0] rdata_q, rd_mux;
   logic [1:0]  rresp_q;

   logic        unused_bits;
   assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, s_axi.S_AXI_AWADDR[1:0],
                          s_axi.S_AXI_ARADDR[1:0], c_strb};

   assign reg_out = regs;

   // ---------------- write path ----------------
   always_comb begin
      s_axi.S_AXI_AWREADY = live && (w_state == W_IDLE || w_state == W_HAVE_W);
      s_axi.S_AXI_WREADY  = live && (w_state == W_IDLE || w_state == W_HAVE_AW);
      s_axi.S_AXI_BVALID  = (w_state == W_RESP);
      s_axi.S_AXI_BRESP   = bresp_q;
      aw_fire = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
      w_fire  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
      // A half captured earlier comes from the holding register, the other half from the bus.
      c_idx  = (w_state == W_HAVE_AW) ? aw_idx_q : s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      c_data = (w_state == W_HAVE_W)  ? wdata_q  : s_axi.S_AXI_WDATA;
      c_strb = (w_state == W_HAVE_W)  ? wstrb_q  : s_axi.S_AXI_WSTRB;
`ifdef EFI_AXIL_WSTRB_EN
      c_mask = strb_mask(c_strb);
`else
      c_mask = '1;
`endif
   end

   always_comb begin
      w_next = w_state;
      commit = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (aw_fire && w_fire) begin
               w_next = W_RESP;
               commit = 1'b1;
            end else if (aw_fire) w_next = W_HAVE_AW;
            else if (w_fire)      w_next = W_HAVE_W;
         end
         W_HAVE_AW: if (w_fire)  begin w_next = W_RESP; commit = 1'b1; end
         W_HAVE_W:  if (aw_fire) begin w_next = W_RESP; commit = 1'b1; end
         W_RESP:    if (s_axi.S_AXI_BREADY) w_next = W_IDLE;
         default:   w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         live     <= 1'b0;
         w_state  <= W_IDLE;
         aw_idx_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp_q  <= RESP_OKAY;
         regs     <= '0;
      end else begin
         live    <= 1'b1;
         w_state <= w_next;
         if (aw_fire) aw_idx_q <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
         if (w_fire) begin
            wdata_q <= s_axi.S_AXI_WDATA;
            wstrb_q <= s_axi.S_AXI_WSTRB;
         end
         if (commit) begin
            bresp_q <= (32'(c_idx) < 32'(C_NUM_REGS)) ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < C_NUM_REGS; i++)
               if (c_idx == IW'(i)) regs[i] <= (regs[i] & ~c_mask) | (c_data & c_mask);
         end
      end
   end

   // ---------------- read path ----------------
   always_comb begin
      s_axi.S_AXI_ARREADY = live && (r_state == R_IDLE);
      s_axi.S_AXI_RVALID  = (r_state == R_DATA);
      s_axi.S_AXI_RDATA   = rdata_q;
      s_axi.S_AXI_RRESP   = rresp_q;
      ar_fire = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
      r_idx   = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
      rd_mux  = '0;
      for (int i = 0; i < C_NUM_REGS; i++)
         if (r_idx == IW'(i)) rd_mux = regs[i];
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_fire) r_next = R_DATA;
         R_DATA:  if (s_axi.S_AXI_RREADY) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state <= R_IDLE;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else begin
         r_state <= r_next;
         if (ar_fire) begin
            rdata_q <= rd_mux;
            rresp_q <= (32'(r_idx) < 32'(C_NUM_REGS)) ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

endmodule

// File: tb/tb_efi_axil_regs.sv
// Self-checking bench for efi_axil_regs: vector table plus hand-written corner sequences.
module tb_efi_axil_regs;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [127:0] reg_out;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   efi_axil_regs_if #(.ADDR_W(5), .DATA_W(32)) bus ();

   efi_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .C_NUM_REGS(4)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(bus), .reg_out(reg_out)
   );

   typedef struct {
      bit          is_wr;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[14];
   logic [1:0]  bq[$];
   logic [33:0] rq[$];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout waiting for handshake", nm);
   endtask

   task automatic send_aw(input logic [4:0] a);
      int t = 0;
      bus.S_AXI_AWADDR = a; bus.S_AXI_AWVALID = 1'b1;
      @(negedge clk);
      while (!bus.S_AXI_AWREADY && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) timeout("aw_handshake");
      @(posedge clk); #1;
      bus.S_AXI_AWVALID = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int t = 0;
      bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s; bus.S_AXI_WVALID = 1'b1;
      @(negedge clk);
      while (!bus.S_AXI_WREADY && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) timeout("w_handshake");
      @(posedge clk); #1;
      bus.S_AXI_WVALID = 1'b0;
   endtask

   task automatic send_ar(input logic [4:0] a);
      int t = 0;
      bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1;
      @(negedge clk);
      while (!bus.S_AXI_ARREADY && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) timeout("ar_handshake");
      @(posedge clk); #1;
      bus.S_AXI_ARVALID = 1'b0;
   endtask

   task automatic get_b();
      int t = 0;
      logic [1:0] exp;
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      while (!bus.S_AXI_BVALID && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) timeout("b_wait");
      exp = (bq.size() != 0) ? bq.pop_front() : 2'bxx;
      check("bresp", 128'(bus.S_AXI_BRESP), 128'(exp));
      @(posedge clk); #1;
      bus.S_AXI_BREADY = 1'b0;
      check("bvalid_drop", 128'(bus.S_AXI_BVALID), 128'(0));
   endtask

   task automatic get_r();
      int t = 0;
      logic [33:0] exp;
      bus.S_AXI_RREADY = 1'b1;
      @(negedge clk);
      while (!bus.S_AXI_RVALID && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) timeout("r_wait");
      exp = (rq.size() != 0) ? rq.pop_front() : 34'bx;
      check("rresp_rdata", 128'({bus.S_AXI_RRESP, bus.S_AXI_RDATA}), 128'(exp));
      @(posedge clk); #1;
      bus.S_AXI_RREADY = 1'b0;
      check("rvalid_drop", 128'(bus.S_AXI_RVALID), 128'(0));
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [1:0] exp);
      bq.push_back(exp);
      fork
         send_aw(a);
         send_w(d, s);
      join
      get_b();
   endtask

   task automatic rd(input logic [4:0] a, input logic [1:0] resp, input logic [31:0] d);
      rq.push_back({resp, d});
      send_ar(a);
      get_r();
   endtask

   initial begin
      logic [1:0]  b0;
      logic [31:0] r0;
      bit ok;
      bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = 3'b010; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = 4'hF;    bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = 3'b101; bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b0;

      vecs[0]  = '{1'b1, 5'h00, 32'h1, 2'b00, 32'h0};
      vecs[1]  = '{1'b1, 5'h04, 32'h2, 2'b00, 32'h0};
      vecs[2]  = '{1'b1, 5'h08, 32'h3, 2'b00, 32'h0};
      vecs[3]  = '{1'b1, 5'h0C, 32'h4, 2'b00, 32'h0};
      vecs[4]  = '{1'b0, 5'h00, 32'h0, 2'b00, 32'h1};
      vecs[5]  = '{1'b0, 5'h04, 32'h0, 2'b00, 32'h2};
      vecs[6]  = '{1'b0, 5'h08, 32'h0, 2'b00, 32'h3};
      vecs[7]  = '{1'b0, 5'h0C, 32'h0, 2'b00, 32'h4};
      vecs[8]  = '{1'b1, 5'h10, 32'hDEADBEEF, 2'b10, 32'h0};
      vecs[9]  = '{1'b0, 5'h14, 32'h0, 2'b10, 32'h0};
      vecs[10] = '{1'b1, 5'h1C, 32'hCAFEF00D, 2'b10, 32'h0};
      vecs[11] = '{1'b0, 5'h0C, 32'h0, 2'b00, 32'h4};
      vecs[12] = '{1'b1, 5'h07, 32'h55, 2'b00, 32'h0};
      vecs[13] = '{1'b0, 5'h05, 32'h0, 2'b00, 32'h55};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 128'(0));
      check("rst_valid", 128'({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP,
                               bus.S_AXI_RRESP}), 128'(0));
      check("rst_data", {bus.S_AXI_RDATA, reg_out[95:0]}, 128'(0));
      @(negedge clk); rst_n = 1'b1; #1;
      check("ready_pre_edge", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 128'(0));
      @(posedge clk); #1;
      check("ready_post_edge", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 128'(7));

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data, 4'hF, vecs[i].resp);
         else               rd(vecs[i].addr, vecs[i].resp, vecs[i].rdata);
      end
      check("reg_out_table", reg_out, {32'h4, 32'h3, 32'h55, 32'h1});

      // AW three cycles ahead of W
      bq.push_back(2'b00);
      send_aw(5'h08);
      check("have_aw_ready", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 128'(2'b01));
      repeat (2) @(posedge clk); #1;
      send_w(32'hA, 4'hF);
      get_b();
      // W three cycles ahead of AW
      bq.push_back(2'b00);
      send_w(32'hB, 4'hF);
      check("have_w_ready", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 128'(2'b10));
      repeat (2) @(posedge clk); #1;
      send_aw(5'h0C);
      get_b();
      check("reg_out_order", reg_out, {32'hB, 32'hA, 32'h55, 32'h1});

      // B channel back-pressure with new requests waiting
      bq.push_back(2'b00);
      fork send_aw(5'h04); send_w(32'h77, 4'hF); join
      b0 = bus.S_AXI_BRESP;
      bus.S_AXI_AWADDR = 5'h00; bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA = 32'hBAD; bus.S_AXI_WVALID = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("b_stall", 128'({bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY,
                                bus.S_AXI_WREADY}), 128'({1'b1, b0, 2'b00}));
      end
      @(posedge clk); #1;
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      get_b();
      check("reg_out_stall", reg_out, {32'hB, 32'hA, 32'h77, 32'h1});

      // R channel back-pressure
      rq.push_back({2'b00, 32'h77});
      send_ar(5'h04);
      r0 = bus.S_AXI_RDATA;
      bus.S_AXI_ARADDR = 5'h00; bus.S_AXI_ARVALID = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("r_stall", 128'({bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RDATA}),
               128'({2'b10, r0}));
      end
      @(posedge clk); #1;
      bus.S_AXI_ARVALID = 1'b0;
      get_r();

      // read on the same edge as a write commit returns the old value
      bq.push_back(2'b00);
      rq.push_back({2'b00, 32'hA});
      fork send_aw(5'h08); send_w(32'h99, 4'hF); send_ar(5'h08); join
      get_b();
      get_r();
      rd(5'h08, 2'b00, 32'h99);

      // byte strobes
      wr(5'h00, 32'h11223344, 4'hF, 2'b00);
      wr(5'h00, 32'hAABBCCDD, 4'b0101, 2'b00);
`ifdef EFI_AXIL_WSTRB_EN
      check("strobe_write", 128'(reg_out[31:0]), 128'(32'h11BB33DD));
`else
      check("strobe_write", 128'(reg_out[31:0]), 128'(32'hAABBCCDD));
`endif

      // reset while holding only the address half of a write
      send_aw(5'h04);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_ctrl", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                                 bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP}), 128'(0));
      check("midrst_data", {bus.S_AXI_RDATA, reg_out[95:0]}, 128'(0));
      @(negedge clk); rst_n = 1'b1;
      ok = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.S_AXI_BVALID) ok = 1'b0;
      end
      check("midrst_no_bvalid", 128'(ok), 128'(1));
      check("midrst_idle", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, reg_out}), {2'b11, 128'(0)});

      check("queues_empty", 128'(bq.size() + rq.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
